// File: rtl/lcd_init_ctrl.sv
// Power-up sequencer for the RGB LCD path: strap ID read, pixel-enable divider, driver reset and backlight.
// Optional build macro LCD_BL_PWM_EN turns lcd_bl into a ramping 8-bit PWM instead of a plain level.
module lcd_init_ctrl #(
  parameter int SETTLE_CYC  = 1000,
  parameter int STABLE_CNT  = 16,
  parameter int SAMPLE_TMO  = 4096,
  parameter int DRV_RST_CYC = 256,
  parameter int BL_DLY_CYC  = 5000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] lcd_rgb_in,
  output logic        lcd_rgb_oe,
  output logic [15:0] id_lcd,
  output logic        id_valid,
  output logic        id_err,
  output logic        lcd_clk_en,
  output logic        drv_rst_n,
  output logic        lcd_bl,
  output logic        ready
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAXP = max2(max2(max2(SETTLE_CYC, STABLE_CNT), max2(SAMPLE_TMO, DRV_RST_CYC)),
                             BL_DLY_CYC);
  localparam int CW   = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] CNT_MAX     = '1;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST    = CW'(SAMPLE_TMO - 1);
  localparam logic [CW-1:0] DRV_LAST    = CW'(DRV_RST_CYC - 1);
  localparam logic [CW-1:0] STAB_DONE   = CW'(STABLE_CNT);
  localparam logic [CW-1:0] BL_AT       = CW'(BL_DLY_CYC);
  localparam logic [CW-1:0] SYNC_FILL   = CW'(2);

  typedef enum logic [2:0] {
    S_SETTLE  = 3'd0,
    S_SAMPLE  = 3'd1,
    S_CONFIG  = 3'd2,
    S_DRV_RST = 3'd3,
    S_RUN     = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   stab_q, stab_d;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      prev_q, prev_d;
  logic [2:0]      id_q, id_d;
  logic            err_q, err_d;
  logic            valid_q, valid_d;
  logic [1:0]      div_m1_q, div_m1_d;
  logic [1:0]      div_cnt_q, div_cnt_d;
  logic            go;
  logic            tmo;
  logic [2:0]      m_sel;
  logic            div_run;
  logic            bl_on;
  logic            unused_rgb;

  assign unused_rgb = ^{lcd_rgb_in[14:11], lcd_rgb_in[9:5], lcd_rgb_in[3:0]};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_SETTLE;
      cnt_q     <= '0;
      stab_q    <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      id_q      <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      div_m1_q  <= 2'd3;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stab_q    <= stab_d;
      sync1_q   <= {lcd_rgb_in[15], lcd_rgb_in[10], lcd_rgb_in[4]};
      sync2_q   <= sync1_q;
      prev_q    <= prev_d;
      id_q      <= id_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      div_m1_q  <= div_m1_d;
      div_cnt_q <= div_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    stab_d   = stab_q;
    prev_d   = prev_q;
    id_d     = id_q;
    err_d    = err_q;
    valid_d  = valid_q;
    div_m1_d = div_m1_q;
    go       = 1'b0;
    tmo      = 1'b0;
    m_sel    = 3'd0;

    case (state_q)
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
          cnt_d   = '0;
        end
      end
      S_SAMPLE: begin
        // The first two SAMPLE cycles only flush the synchroniser; stability counting starts after.
        if (stab_q == STAB_DONE) begin
          go    = 1'b1;
          m_sel = prev_q;
        end else if (cnt_q == TMO_LAST) begin
          go  = 1'b1;
          tmo = 1'b1;
        end else if (cnt_q >= SYNC_FILL) begin
          prev_d = sync2_q;
          stab_d = (stab_q == '0 || sync2_q != prev_q) ? CW'(1) : stab_q + 1'b1;
        end
        if (go) begin
          state_d = S_CONFIG;
          cnt_d   = '0;
          valid_d = 1'b1;
          err_d   = tmo;
          case (m_sel)
            3'd0:    begin id_d = 3'd0; div_m1_d = 2'd3; end
            3'd1:    begin id_d = 3'd1; div_m1_d = 2'd1; end
            3'd2:    begin id_d = 3'd2; div_m1_d = 2'd0; end
            3'd5:    begin id_d = 3'd5; div_m1_d = 2'd0; end
            default: begin id_d = 3'd0; div_m1_d = 2'd3; err_d = 1'b1; end
          endcase
        end
      end
      S_CONFIG: begin
        state_d = S_DRV_RST;
        cnt_d   = '0;
      end
      S_DRV_RST: begin
        if (cnt_q == DRV_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_SETTLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign div_run    = (state_q == S_CONFIG) || (state_q == S_DRV_RST) || (state_q == S_RUN);
  assign lcd_clk_en = div_run && (div_cnt_q == div_m1_q);
  assign div_cnt_d  = (!div_run || lcd_clk_en) ? 2'd0 : div_cnt_q + 2'd1;

  assign lcd_rgb_oe = (state_q == S_DRV_RST) || (state_q == S_RUN);
  assign drv_rst_n  = (state_q == S_RUN);
  assign ready      = (state_q == S_RUN);
  assign id_lcd     = {13'd0, id_q};
  assign id_valid   = valid_q;
  assign id_err     = err_q;
  // The RUN counter saturates, so this compare holds for the rest of RUN.
  assign bl_on      = (state_q == S_RUN) && (cnt_q >= BL_AT);

`ifdef LCD_BL_PWM_EN
  logic [7:0] pwm_cnt_q, pwm_cnt_d;
  logic [7:0] duty_q, duty_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pwm_cnt_q <= '0;
      duty_q    <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      duty_q    <= duty_d;
    end
  end

  always_comb begin
    pwm_cnt_d = '0;
    duty_d    = '0;
    if (bl_on) begin
      pwm_cnt_d = pwm_cnt_q + 8'd1;
      duty_d    = (pwm_cnt_q == 8'hFF && duty_q != 8'hFF) ? duty_q + 8'd1 : duty_q;
    end
  end

  assign lcd_bl = bl_on && ((duty_q == 8'hFF) || (pwm_cnt_q < duty_q));
`else
  assign lcd_bl = bl_on;
`endif

endmodule

// File: tb/tb_lcd_init_ctrl.sv
// Directed bench for lcd_init_ctrl: strap decode, stability/timeout, divider, driver release, backlight, reset.
module tb_lcd_init_ctrl;

  localparam int SETTLE_CYC  = 1000;
  localparam int STABLE_CNT  = 16;
  localparam int SAMPLE_TMO  = 4096;
  localparam int DRV_RST_CYC = 256;
  localparam int BL_DLY_CYC  = 5000;

  localparam int T_ID_STABLE = SETTLE_CYC + 2 + STABLE_CNT + 1;
  localparam int T_ID_TMO    = SETTLE_CYC + SAMPLE_TMO;
  // Divider is sampled for 16 cycles after CONFIG, then RUN follows 1 + DRV_RST_CYC edges after CONFIG.
  localparam int T_RUN_AFTER = 1 + DRV_RST_CYC - 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic [15:0] lcd_rgb_in;
  logic        lcd_rgb_oe;
  logic [15:0] id_lcd;
  logic        id_valid;
  logic        id_err;
  logic        lcd_clk_en;
  logic        drv_rst_n;
  logic        lcd_bl;
  logic        ready;

  logic [15:0] strap_word = 16'h0000;
  logic        toggle_en  = 1'b0;
  logic [7:0]  tcnt       = 8'd0;

  int checks   = 0;
  int failures = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) tcnt <= tcnt + 8'd1;

  function automatic logic [15:0] strap(input logic [2:0] m, input logic [15:0] noise);
    logic [15:0] w;
    w = noise & ~16'h8410;
    w[15] = m[2];
    w[10] = m[1];
    w[4]  = m[0];
    return w;
  endfunction

  assign lcd_rgb_in = toggle_en ? strap({1'b0, tcnt[3], 1'b0}, 16'h5A3C) : strap_word;

  lcd_init_ctrl dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .lcd_rgb_in (lcd_rgb_in),
    .lcd_rgb_oe (lcd_rgb_oe),
    .id_lcd     (id_lcd),
    .id_valid   (id_valid),
    .id_err     (id_err),
    .lcd_clk_en (lcd_clk_en),
    .drv_rst_n  (drv_rst_n),
    .lcd_bl     (lcd_bl),
    .ready      (ready)
  );

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return id_valid;
      1:       return drv_rst_n;
      2:       return ready;
      default: return lcd_bl;
    endcase
  endfunction

  task automatic wait_rise(input int which, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge sys_clk);
      if (sig(which) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  function automatic int outs_packed();
    return int'({lcd_rgb_oe, id_valid, id_err, lcd_clk_en, drv_rst_n, lcd_bl, ready});
  endfunction

  task automatic do_reset(input string tag);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk({tag, "_rst_outs"}, outs_packed(), 0);
    chk({tag, "_rst_id"}, int'(id_lcd), 0);
    sys_rst_n = 1'b1;
  endtask

  task automatic check_divider(input string tag, input int div);
    int ones, first, second;
    ones = 0; first = -1; second = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge sys_clk);
      if (lcd_clk_en === 1'b1) begin
        ones++;
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    chk({tag, "_en_ones"}, ones, 16 / div);
    chk({tag, "_en_gap"}, second - first, div);
  endtask

  task automatic acquire(input string tag, input int t_exp, input int id_exp, input int err_exp,
                         input int div);
    int n;
    wait_rise(0, T_ID_TMO + 100, n);
    chk({tag, "_id_time"}, n, t_exp);
    chk({tag, "_id"}, int'(id_lcd), id_exp);
    chk({tag, "_err"}, int'(id_err), err_exp);
    chk({tag, "_oe_config"}, int'(lcd_rgb_oe), 0);
    check_divider(tag, div);
  endtask

  initial begin
    int n;

    // 1: M=1 steady, DIV=2, driver release timing, later strap activity ignored
    strap_word = strap(3'd1, 16'hFFFF);
    do_reset("t1");
    acquire("t1", T_ID_STABLE, 1, 0, 2);
    chk("t1_oe_drv_rst", int'(lcd_rgb_oe), 1);
    chk("t1_drv_low", int'(drv_rst_n), 0);
    wait_rise(1, 400, n);
    chk("t1_drv_release", n, T_RUN_AFTER);
    chk("t1_ready", int'(ready), 1);
    strap_word = strap(3'd6, 16'h0000);
    repeat (20) @(negedge sys_clk);
    chk("t1_id_hold", int'(id_lcd), 1);
    chk("t1_err_hold", int'(id_err), 0);

    // 2: straps toggle 0<->2 every 8 cycles, timeout falls back to ID 0 with error
    toggle_en = 1'b1;
    do_reset("t2");
    acquire("t2", T_ID_TMO, 0, 1, 4);
    wait_rise(2, 400, n);
    chk("t2_ready", n, T_RUN_AFTER);
    toggle_en = 1'b0;

    // 3: unsupported code M=6
    strap_word = strap(3'd6, 16'h2222);
    do_reset("t3");
    acquire("t3", T_ID_STABLE, 0, 1, 4);

    // 4: M=5, pixel enable constantly high, backlight delay
    strap_word = strap(3'd5, 16'h0F0F);
    do_reset("t4");
    acquire("t4", T_ID_STABLE, 5, 0, 1);
    wait_rise(2, 400, n);
    chk("t4_ready", n, T_RUN_AFTER);
`ifdef LCD_BL_PWM_EN
    repeat (BL_DLY_CYC - 1) @(negedge sys_clk);
    for (int p = 0; p < 3; p++) begin
      int high;
      high = 0;
      for (int i = 0; i < 256; i++) begin
        @(negedge sys_clk);
        if (lcd_bl === 1'b1) high++;
      end
      chk("t4_pwm_high", high, p);
    end
`else
    chk("t4_bl_low", int'(lcd_bl), 0);
    wait_rise(3, BL_DLY_CYC + 100, n);
    chk("t4_bl_delay", n, BL_DLY_CYC);
`endif

    // 5: reset pulse in DRV_RST clears outputs asynchronously, same ID re-acquired
    strap_word = strap(3'd2, 16'hA5A5);
    do_reset("t5");
    acquire("t5", T_ID_STABLE, 2, 0, 1);
    repeat (30) @(negedge sys_clk);
    chk("t5_in_drv_rst", int'({lcd_rgb_oe, drv_rst_n}), 2);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("t5_async_outs", outs_packed(), 0);
    chk("t5_async_id", int'(id_lcd), 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    acquire("t5b", T_ID_STABLE, 2, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
